scan_mux: RTL and testbench
===========================

SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter NCH, default 2, number of multiplexed channels (legal 2..8).
REQ-002 Parameter W, default 4, data width per channel (legal 1..16).
REQ-003 Parameter DIV, default 1000, clock cycles per channel slot (legal 2..2^20).
REQ-004 Parameter BLANK, default 2, blanking cycles at the start of each slot (legal 0..DIV-1).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  scan enable; slot counter advances only when high.
REQ-008 ch_mask  input  NCH  per-channel active mask, 1 = channel participates in scan.
REQ-009 din  input  NCH*W  packed channel data, channel i at bits [i*W +: W].
REQ-010 dout  output  W  data of currently selected channel.
REQ-011 an  output  NCH  one-hot active-high channel enable (all zero when blanked).
REQ-012 idx  output  clog2(NCH)  index of currently selected channel.
REQ-013 tick  output  1  single-cycle pulse marking a slot boundary.

Function
REQ-014 State: slot counter cnt (0..DIV-1) and channel register idx; no other architectural state.
REQ-015 en high, cnt < DIV-1: cnt increments by 1 each clock; idx unchanged.
REQ-016 en high, cnt == DIV-1: cnt wraps to 0 and idx loads next channel on same edge.
REQ-017 en low: cnt and idx hold; outputs remain a pure function of held state and inputs.
REQ-018 Next channel = first index j with ch_mask[j]=1, searching idx+1, idx+2, ... modulo NCH, ending at idx itself.
REQ-019 Wrap: search passes from NCH-1 to 0; non-power-of-two NCH never yields idx >= NCH.
REQ-020 Only current idx set in ch_mask: idx stays unchanged at boundary.
REQ-021 ch_mask all zero at boundary: idx holds.
REQ-022 dout = din slice at idx, combinational from idx and din; dout is 0 when ch_mask[idx]=0.
REQ-023 an = one-hot(idx) when cnt >= BLANK and ch_mask[idx]=1; otherwise all zero.
REQ-024 BLANK = 0: an never blanked by cnt; gated only by ch_mask.
REQ-025 Mask change mid-slot: an/dout react in the same cycle (combinational); idx changes only at slot boundary.
REQ-026 tick = en AND (cnt == DIV-1), combinational; high exactly one cycle per slot while en stays high.
REQ-027 an never has more than one bit set in any cycle, including reset release and mask changes.
REQ-028 din changes mid-slot propagate to dout in the same cycle; no input latching.

Reset
REQ-029 reset high at a rising edge: cnt <= 0, idx <= 0, regardless of en or ch_mask.
REQ-030 reset has priority over en and slot advance in the same cycle.
REQ-031 During and after reset until cnt reaches BLANK: an = 0; tick = 0; dout = din slice 0 (or 0 if ch_mask[0]=0).
REQ-032 reset asserted mid-slot aborts the slot; first post-reset slot is a full DIV cycles on channel 0.

Verification (NCH=2, W=4, DIV=4, BLANK=1 unless stated)
REQ-033 Reset, ch_mask=2'b11, din={4'hA,4'h5}, en=1 -> cycles 0..3: an=00,01,01,01, dout=5; tick high at cnt=3; then idx=1, an=00,10,10,10, dout=A; alternation repeats.
REQ-034 ch_mask=2'b10 from reset -> idx moves 0->1 at first boundary, then stays 1; an=10 except blank cycle; an never 01.
REQ-035 en held low 10 cycles mid-slot at cnt=2 -> cnt, idx, an, dout frozen; tick=0; scan resumes at cnt=3 when en returns.
REQ-036 ch_mask=2'b00 -> an=00 and dout=0 every cycle; idx holds; tick still pulses every 4 cycles.
REQ-037 NCH=3, DIV=2, BLANK=0, ch_mask=3'b101 -> idx sequence 0,2,0,2 each slot; an=001,100 alternating; idx never 1 or 3.
REQ-038 reset pulsed at idx=1, cnt=2 -> next cycle cnt=0, idx=0, an=00; full 4-cycle slot on channel 0 follows.

Source files
------------

// File: rtl/scan_mux.sv
// scan_mux: time-multiplexed channel scanner with per-slot blanking.
// clk/reset/en/ch_mask/din in; dout/an/idx/tick out.
module scan_mux #(
  parameter int NCH   = 2,
  parameter int W     = 4,
  parameter int DIV   = 1000,
  parameter int BLANK = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NCH-1:0]           ch_mask,
  input  logic [NCH*W-1:0]         din,
  output logic [W-1:0]             dout,
  output logic [NCH-1:0]           an,
  output logic [$clog2(NCH)-1:0]   idx,
  output logic                     tick
);

  localparam int IW = $clog2(NCH);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;

  logic          w_wrap;
  logic          w_open;
  logic          w_msk;
  logic          w_live;
  logic [W-1:0]  w_sel;
  logic [IW-1:0] w_nxt;
  logic          w_fnd;
  logic [NCH-1:0] w_an;
  int            w_j;

  assign w_wrap = en & (r_cnt == LAST);

  // Blanking window opens once the slot counter reaches BLANK.
  generate
    if (BLANK == 0) begin : g_noblank
      assign w_open = 1'b1;
    end else begin : g_blank
      assign w_open = (r_cnt >= CW'(BLANK));
    end
  endgenerate

  // Round-robin search starting just after the current channel,
  // ending at the current channel itself; holds when mask is empty.
  always_comb begin
    w_nxt = r_idx;
    w_fnd = 1'b0;
    w_j   = 0;
    for (int k = 1; k <= NCH; k++) begin
      w_j = int'(r_idx) + k;
      if (w_j >= NCH) w_j = w_j - NCH;
      if (!w_fnd && ch_mask[w_j]) begin
        w_nxt = IW'(w_j);
        w_fnd = 1'b1;
      end
    end
  end

  // Explicit decode keeps indexing in range for non-power-of-two NCH.
  always_comb begin
    w_sel = '0;
    w_msk = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (r_idx == IW'(i)) begin
        w_sel = din[i*W +: W];
        w_msk = ch_mask[i];
      end
    end
  end

  assign w_live = w_open & w_msk;

  always_comb begin
    w_an = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_idx == IW'(i)) w_an[i] = w_live;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (en) begin
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= w_nxt;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign dout = w_msk ? w_sel : '0;
  assign an   = w_an;
  assign idx  = r_idx;
  assign tick = w_wrap;

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: randomized check of scan_mux against a slot-level model.
// Two instances: NCH=2/DIV=4/BLANK=1 and NCH=3/DIV=2/BLANK=0.
module tb_scan_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] ch_mask;
  logic [7:0] din;
  logic [3:0] dout;
  logic [1:0] an;
  logic [0:0] idx;
  logic       tick;

  logic [2:0]  ch_mask3;
  logic [11:0] din3;
  logic [3:0]  dout3;
  logic [2:0]  an3;
  logic [1:0]  idx3;
  logic        tick3;

  int n_chk  = 0;
  int n_pass = 0;

  int m_cnt, m_idx, m3_cnt, m3_idx;

  always #5 clk = ~clk;

  scan_mux #(.NCH(2), .W(4), .DIV(4), .BLANK(1)) u_dut (
    .clk(clk), .reset(reset), .en(en), .ch_mask(ch_mask),
    .din(din), .dout(dout), .an(an), .idx(idx), .tick(tick)
  );

  scan_mux #(.NCH(3), .W(4), .DIV(2), .BLANK(0)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .ch_mask(ch_mask3),
    .din(din3), .dout(dout3), .an(an3), .idx(idx3), .tick(tick3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Next channel: smallest active channel above cur, else the
  // smallest active channel overall, else stay.
  function automatic int nxt(int nch, logic [7:0] m, int cur);
    int first = -1;
    int after = -1;
    for (int j = 0; j < nch; j++) begin
      if (m[j]) begin
        if (first < 0) first = j;
        if (j > cur && after < 0) after = j;
      end
    end
    if (after >= 0) return after;
    if (first >= 0) return first;
    return cur;
  endfunction

  function automatic int e_dout(logic [7:0] m, logic [31:0] d, int i);
    return m[i] ? int'((d >> (i * 4)) & 32'hF) : 0;
  endfunction

  function automatic int e_an(logic [7:0] m, int i, int c, int blank);
    return (c >= blank && m[i]) ? (1 << i) : 0;
  endfunction

  task automatic step(input int nch, input int div, input logic [7:0] m,
                      inout int c, inout int i);
    if (reset) begin
      c = 0;
      i = 0;
    end else if (en) begin
      if (c == div - 1) begin
        c = 0;
        i = nxt(nch, m, i);
      end else begin
        c = c + 1;
      end
    end
  endtask

  task automatic cyc();
    #1;
    chk("dout", 32'(dout), 32'(e_dout(8'(ch_mask), 32'(din), m_idx)));
    chk("an", 32'(an), 32'(e_an(8'(ch_mask), m_idx, m_cnt, 1)));
    chk("idx", 32'(idx), 32'(m_idx));
    chk("tick", 32'(tick), 32'(en && m_cnt == 3));
    chk("an_1h", 32'($countones(an) <= 1), 32'd1);
    chk("dout3", 32'(dout3), 32'(e_dout(8'(ch_mask3), 32'(din3), m3_idx)));
    chk("an3", 32'(an3), 32'(e_an(8'(ch_mask3), m3_idx, m3_cnt, 0)));
    chk("idx3", 32'(idx3), 32'(m3_idx));
    chk("tick3", 32'(tick3), 32'(en && m3_cnt == 1));
    chk("idx3_rng", 32'(idx3 < 2'd3), 32'd1);
    step(2, 4, 8'(ch_mask), m_cnt, m_idx);
    step(3, 2, 8'(ch_mask3), m3_cnt, m3_idx);
    @(negedge clk);
  endtask

  initial begin
    m_cnt = 0; m_idx = 0; m3_cnt = 0; m3_idx = 0;
    reset = 1'b1; en = 1'b1;
    ch_mask = 2'b11; din = 8'hA5;
    ch_mask3 = 3'b101; din3 = 12'h321;
    @(negedge clk);
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'd0);
    chk("rst_dout", 32'(dout), 32'h5);
    chk("rst_tick", 32'(tick), 32'd0);
    repeat (16) cyc();
    reset = 1'b1; cyc();
    reset = 1'b0; ch_mask = 2'b10;
    repeat (12) cyc();
    ch_mask = 2'b11;
    while (m_cnt != 2) cyc();
    en = 1'b0;
    repeat (10) cyc();
    en = 1'b1;
    repeat (6) cyc();
    ch_mask = 2'b00; ch_mask3 = 3'b000;
    repeat (10) cyc();
    ch_mask = 2'b11; ch_mask3 = 3'b101;
    while (!(m_idx == 1 && m_cnt == 2)) cyc();
    reset = 1'b1; cyc();
    reset = 1'b0;
    repeat (8) cyc();
    for (int n = 0; n < 3000; n++) begin
      en    = ($urandom_range(0, 7) != 0);
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) ch_mask = 2'($urandom);
      if ($urandom_range(0, 9) == 0) ch_mask3 = 3'($urandom);
      if ($urandom_range(0, 3) == 0) din = 8'($urandom);
      if ($urandom_range(0, 3) == 0) din3 = 12'($urandom);
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
